wb_intercon: RTL
================

WB_INTERCON -- requirements
Module: wb_intercon

Interface
REQ-001 SHALL have parameter NSLV, default 4, number of slave ports (1..16).
REQ-002 SHALL have parameter AW, default 30, word-address width.
REQ-003 SHALL have parameter DW, default 32, data width (multiple of 8).
REQ-004 SHALL have parameter SLV_BASE, default 0, NSLV*AW flattened base addresses, slave 0 in LSBs.
REQ-005 SHALL have parameter SLV_MASK, default 0, NSLV*AW flattened compare masks, slave 0 in LSBs.
REQ-006 SHALL have parameter TIMEOUT, default 255, max cycles waiting for slave ack; 0 disables timeout.
REQ-007 SHALL have ports clk_i in 1, sole clock; rst_i in 1, reset, asynchronous, active-high.
REQ-008 SHALL have ports m_cyc_i in 1, m_stb_i in 1, m_we_i in 1, m_sel_i in DW/8, m_adr_i in AW, m_dat_i in DW: master request.
REQ-009 SHALL have ports m_ack_o out 1, m_err_o out 1, m_dat_o out DW: master response.
REQ-010 SHALL have ports s_cyc_o out NSLV, s_stb_o out NSLV: per-slave one-hot strobes.
REQ-011 SHALL have ports s_we_o out 1, s_sel_o out DW/8, s_adr_o out AW, s_dat_o out DW: shared registered request.
REQ-012 SHALL have ports s_ack_i in NSLV, s_dat_i in NSLV*DW: per-slave responses, slave 0 in LSBs.
REQ-013 SHALL have ports err_adr_o out AW, last faulting address; err_cnt_o out 8, saturating error count.

Function
REQ-014 SHALL implement FSM states IDLE, ACTIVE, RESP.
REQ-015 In IDLE, on m_cyc_i&m_stb_i, slave i SHALL match when (m_adr_i & mask_i) == (base_i & mask_i).
REQ-016 On overlapping matches the lowest index SHALL win.
REQ-017 On match, SHALL register index, adr, we, sel, dat and enter ACTIVE.
REQ-018 On no match, SHALL enter RESP with error flag set; no slave strobed.
REQ-019 In ACTIVE, s_cyc_o[idx] and s_stb_o[idx] SHALL be high; all other bits low.
REQ-020 In ACTIVE, s_ack_i[idx] SHALL capture the idx data slice into m_dat_o and enter RESP with ack flag, dropping strobes in the same cycle.
REQ-021 s_ack_i of non-selected slaves SHALL be ignored in every state.
REQ-022 The ACTIVE cycle counter SHALL clear on entry; at count==TIMEOUT (TIMEOUT!=0) without ack, SHALL drop strobes and enter RESP with error flag.
REQ-023 Ack and timeout in the same cycle: ack SHALL win.
REQ-024 In RESP, exactly one of m_ack_o/m_err_o SHALL be high for exactly one cycle; next state IDLE.
REQ-025 Latency: request cycle 0 -> s_stb_o cycle 1; slave ack cycle k -> m_ack_o cycle k+1; decode miss -> m_err_o cycle 1.
REQ-026 Back-to-back: new request SHALL be accepted no earlier than the cycle after RESP.
REQ-027 m_cyc_i low in ACTIVE SHALL abort to IDLE, drop strobes the next cycle, and give no ack/err.
REQ-028 On each error, err_adr_o SHALL load the registered adr; err_cnt_o SHALL increment, saturating at 255.
REQ-029 m_dat_o SHALL hold its value outside RESP.

Reset
REQ-030 rst_i high SHALL force IDLE immediately; all outputs, counters, registers SHALL be zero.
REQ-031 Reset during ACTIVE SHALL drop strobes asynchronously; no response issued.

Structure
REQ-032 FSM state encoding and default TIMEOUT SHALL reside in shared package wb_pkg.
REQ-033 The address match SHALL be a sub-module wb_addr_match (combinational, parametrised NSLV/AW) returning hit and index.

Verification
REQ-034 NSLV=4, slave 2 base 0x100 mask 0x3FFFFF00: read 0x105, slave acks at cycle 3 with 0xDEADBEEF -> s_stb_o=4'b0100 cycle 1, m_ack_o cycle 4, m_dat_o=0xDEADBEEF.
REQ-035 Access unmapped 0x3FFF0000 -> m_err_o cycle 1, err_adr_o=0x3FFF0000, err_cnt_o=1, s_stb_o never set.
REQ-036 TIMEOUT=8, selected slave silent -> strobes drop, m_err_o one cycle, err_cnt_o increments.
REQ-037 Slaves 0,1 overlapping on 0x0 -> only s_stb_o[0] asserted; spurious s_ack_i[3] during ACTIVE ignored.
REQ-038 m_cyc_i dropped at cycle 2 of ACTIVE -> IDLE, no ack/err; rst_i mid-ACTIVE -> all outputs 0 same cycle.
REQ-039 260 unmapped accesses -> err_cnt_o saturates at 255.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types, constants and helpers for the Wishbone single-master interconnect.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int DEFAULT_TIMEOUT = 255;
  localparam int ERR_CNT_W       = 8;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == {ERR_CNT_W{1'b1}}) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/wb_addr_match.sv
// Combinational address decoder: reports whether any slave window matches and
// which slave owns the address, with the lowest index winning on overlap.
module wb_addr_match
  import wb_pkg::*;
#(
  parameter int                 NSLV     = 4,
  parameter int                 AW       = 30,
  parameter logic [NSLV*AW-1:0] SLV_BASE = '0,
  parameter logic [NSLV*AW-1:0] SLV_MASK = '0,
  parameter int                 IW       = idx_width(NSLV)
) (
  input  logic [AW-1:0] adr_i,
  output logic          hit_o,
  output logic [IW-1:0] idx_o
);

  // Scanning from the top down lets lower-indexed matches overwrite higher ones.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((adr_i & SLV_MASK[i*AW +: AW]) == (SLV_BASE[i*AW +: AW] & SLV_MASK[i*AW +: AW])) begin
        hit_o = 1'b1;
        idx_o = IW'(i);
      end
    end
  end

endmodule

// File: rtl/wb_intercon.sv
// Single-master, NSLV-slave Wishbone interconnect with registered request path,
// decode-miss and timeout error responses, and a sticky error address/counter.
module wb_intercon
  import wb_pkg::*;
#(
  parameter int                 NSLV     = 4,
  parameter int                 AW       = 30,
  parameter int                 DW       = 32,
  parameter logic [NSLV*AW-1:0] SLV_BASE = '0,
  parameter logic [NSLV*AW-1:0] SLV_MASK = '0,
  parameter int                 TIMEOUT  = DEFAULT_TIMEOUT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,

  input  logic                 m_cyc_i,
  input  logic                 m_stb_i,
  input  logic                 m_we_i,
  input  logic [DW/8-1:0]      m_sel_i,
  input  logic [AW-1:0]        m_adr_i,
  input  logic [DW-1:0]        m_dat_i,

  output logic                 m_ack_o,
  output logic                 m_err_o,
  output logic [DW-1:0]        m_dat_o,

  output logic [NSLV-1:0]      s_cyc_o,
  output logic [NSLV-1:0]      s_stb_o,
  output logic                 s_we_o,
  output logic [DW/8-1:0]      s_sel_o,
  output logic [AW-1:0]        s_adr_o,
  output logic [DW-1:0]        s_dat_o,

  input  logic [NSLV-1:0]      s_ack_i,
  input  logic [NSLV*DW-1:0]   s_dat_i,

  output logic [AW-1:0]        err_adr_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam int                IW        = idx_width(NSLV);
  localparam int                CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);

  state_e                 state_q,   state_d;
  logic [IW-1:0]          idx_q,     idx_d;
  logic [AW-1:0]          adr_q,     adr_d;
  logic                   we_q,      we_d;
  logic [DW/8-1:0]        sel_q,     sel_d;
  logic [DW-1:0]          dat_q,     dat_d;
  logic [NSLV-1:0]        stb_q,     stb_d;
  logic [CNT_W-1:0]       cnt_q,     cnt_d;
  logic                   m_ack_q,   m_ack_d;
  logic                   m_err_q,   m_err_d;
  logic [DW-1:0]          m_dat_q,   m_dat_d;
  logic [AW-1:0]          err_adr_q, err_adr_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic                   match_hit;
  logic [IW-1:0]          match_idx;
  logic                   sel_ack;
  logic [DW-1:0]          sel_dat;

  wb_addr_match #(
    .NSLV     (NSLV),
    .AW       (AW),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK),
    .IW       (IW)
  ) u_match (
    .adr_i (m_adr_i),
    .hit_o (match_hit),
    .idx_o (match_idx)
  );

  // Only the slave we actually strobed may complete the cycle.
  always_comb begin
    sel_ack = 1'b0;
    sel_dat = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (idx_q == IW'(i)) begin
        sel_ack = s_ack_i[i];
        sel_dat = s_dat_i[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    adr_d     = adr_q;
    we_d      = we_q;
    sel_d     = sel_q;
    dat_d     = dat_q;
    stb_d     = stb_q;
    cnt_d     = cnt_q;
    m_ack_d   = 1'b0;
    m_err_d   = 1'b0;
    m_dat_d   = m_dat_q;
    err_adr_d = err_adr_q;
    err_cnt_d = err_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          adr_d = m_adr_i;
          we_d  = m_we_i;
          sel_d = m_sel_i;
          dat_d = m_dat_i;
          if (match_hit) begin
            idx_d = match_idx;
            cnt_d = '0;
            for (int i = 0; i < NSLV; i++) begin
              stb_d[i] = (match_idx == IW'(i));
            end
            state_d = ACTIVE;
          end else begin
            m_err_d   = 1'b1;
            err_adr_d = m_adr_i;
            err_cnt_d = sat_inc(err_cnt_q);
            state_d   = RESP;
          end
        end
      end

      // An abandoned cycle returns silently; a real ack beats a coincident timeout.
      ACTIVE: begin
        if (!m_cyc_i) begin
          stb_d   = '0;
          state_d = IDLE;
        end else if (sel_ack) begin
          stb_d   = '0;
          m_ack_d = 1'b1;
          m_dat_d = sel_dat;
          state_d = RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == TIMEOUT_C)) begin
          stb_d     = '0;
          m_err_d   = 1'b1;
          err_adr_d = adr_q;
          err_cnt_d = sat_inc(err_cnt_q);
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        stb_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      adr_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      dat_q     <= '0;
      stb_q     <= '0;
      cnt_q     <= '0;
      m_ack_q   <= 1'b0;
      m_err_q   <= 1'b0;
      m_dat_q   <= '0;
      err_adr_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      adr_q     <= adr_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      dat_q     <= dat_d;
      stb_q     <= stb_d;
      cnt_q     <= cnt_d;
      m_ack_q   <= m_ack_d;
      m_err_q   <= m_err_d;
      m_dat_q   <= m_dat_d;
      err_adr_q <= err_adr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign m_ack_o   = m_ack_q;
  assign m_err_o   = m_err_q;
  assign m_dat_o   = m_dat_q;
  assign s_cyc_o   = stb_q;
  assign s_stb_o   = stb_q;
  assign s_we_o    = we_q;
  assign s_sel_o   = sel_q;
  assign s_adr_o   = adr_q;
  assign s_dat_o   = dat_q;
  assign err_adr_o = err_adr_q;
  assign err_cnt_o = err_cnt_q;

endmodule
